// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, widths and the address check for the data-memory responder.
//   state_t   - responder FSM states (IDLE, WAIT, RESP)
//   DATA_W    - data word width in bits
//   BE_W      - number of byte enables per word
//   addr_err  - 1 when a byte address is misaligned or beyond the store
package dmem_pkg;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Widened compare so DEPTH_WORDS*4 cannot wrap for large stores.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || (64'(addr) >= 64'(depth_words) * 64'd4);
    endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: byte-enabled synchronous word store with registered read.
//   clk   - clock
//   we    - write strobe; bytes selected by be are written at the edge
//   re    - read strobe; rdata updates at the edge and holds otherwise
//   addr  - word index
//   wdata - write data
//   be    - byte enables, bit i selects byte i
//   rdata - registered read data
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic                           re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [DATA_W-1:0]              wdata,
    input  logic [BE_W-1:0]                be,
    output logic [DATA_W-1:0]              rdata
);
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++)
            if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with fixed response latency.
//   clk, reset              - clock, synchronous active-high reset
//   req_valid/req_ready     - request handshake (ready only in IDLE)
//   req_write               - 1 store, 0 load
//   req_addr                - byte address
//   req_wdata/req_be        - store data and byte enables
//   rsp_valid/rsp_ready     - response handshake
//   rsp_rdata               - load data, 0 for stores and errors
//   rsp_err                 - misaligned or out-of-range request
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              write_q, err_q;
    logic              accept, err;
    logic [DATA_W-1:0] arr_rdata;

    assign accept = req_valid && (state == IDLE);
    assign err    = addr_err(req_addr, DEPTH_WORDS);

    // Stores commit and loads sample memory on the acceptance edge itself;
    // the array output then holds until the next accepted load.
    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .we    (accept && req_write && !err),
        .re    (accept && !req_write && !err),
        .addr  (req_addr[AW+1:2]),
        .wdata (req_wdata),
        .be    (req_be),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                write_q <= req_write;
                err_q   <= err;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = (rsp_valid && !write_q && !err_q) ? arr_rdata : '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nx   = 4'(LATENCY - 1);
                    state_nx = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) state_nx = RESP;
            end
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder at LATENCY 2 and 1.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic [3:0]  a_req_be;
    logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [3:0]  b_req_be;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_xfer(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err,
                          output int lat);
        int guard = 0;
        while (!a_req_ready && guard < 20) begin
            step();
            guard++;
        end
        a_req_valid = 1'b1;
        a_req_write = w;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        a_req_be    = be;
        step();
        a_req_valid = 1'b0;
        lat = 1;
        while (!a_rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        rdata = a_rsp_rdata;
        err   = a_rsp_err;
        a_rsp_ready = 1'b1;
        step();
        a_rsp_ready = 1'b0;
    endtask

    task automatic a_access(input string tag, input logic w, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        a_xfer(w, addr, wdata, be, rd, er, lat);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_rdata"}, rd, exp_rdata);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        check({tag, "_ready_after"}, 32'(a_req_ready), 32'd1);
    endtask

    initial begin
        int guard;
        int nresp;
        reset = 1'b1;
        {a_req_valid, a_req_write, a_rsp_ready, a_req_addr, a_req_wdata, a_req_be} = '0;
        {b_req_valid, b_req_write, b_rsp_ready, b_req_addr, b_req_wdata, b_req_be} = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_req_ready", 32'(a_req_ready), 32'd1);
        check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("rst_rsp_rdata", a_rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(a_rsp_err), 32'd0);
        check("rst_b_req_ready", 32'(b_req_ready), 32'd1);

        // Basic store then load.
        a_access("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        a_access("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Byte-enable merge.
        a_access("st20", 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
        a_access("st20_be5", 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0);
        a_access("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

        // Error cases, errored stores leave memory untouched, be=0 is a no-op.
        a_access("ld22_mis", 1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1);
        a_access("ld400_oor", 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1);
        a_access("st0", 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        a_access("st400_oor", 1'b1, 32'h400, 32'h55555555, 4'hF, 32'h0, 1'b1);
        a_access("st12_mis", 1'b1, 32'h12, 32'h66666666, 4'hF, 32'h0, 1'b1);
        a_access("st10_be0", 1'b1, 32'h10, 32'h77777777, 4'h0, 32'h0, 1'b0);
        a_access("ld0_after", 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        a_access("ld10_after", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        a_access("st3fc", 1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
        a_access("ld3fc", 1'b0, 32'h3FC, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);

        // Backpressure: response held for 5 cycles, a stray store meanwhile is ignored.
        a_req_valid = 1'b1;
        a_req_write = 1'b0;
        a_req_addr  = 32'h10;
        step();
        a_req_valid = 1'b0;
        guard = 0;
        while (!a_rsp_valid && guard < 20) begin
            step();
            guard++;
        end
        a_req_valid = 1'b1;
        a_req_write = 1'b1;
        a_req_wdata = 32'h0;
        a_req_be    = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(a_rsp_valid), 32'd1);
            check("hold_rdata", a_rsp_rdata, 32'hDEADBEEF);
            check("hold_err", 32'(a_rsp_err), 32'd0);
            check("hold_req_ready", 32'(a_req_ready), 32'd0);
            step();
        end
        a_req_valid = 1'b0;
        a_rsp_ready = 1'b1;
        step();
        a_rsp_ready = 1'b0;
        check("hold_release_ready", 32'(a_req_ready), 32'd1);
        check("hold_release_valid", 32'(a_rsp_valid), 32'd0);
        a_access("ld10_post_hold", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Reset while waiting drops the response.
        a_req_valid = 1'b1;
        a_req_write = 1'b0;
        a_req_addr  = 32'h10;
        step();
        a_req_valid = 1'b0;
        check("wait_valid", 32'(a_rsp_valid), 32'd0);
        check("wait_req_ready", 32'(a_req_ready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("wrst_req_ready", 32'(a_req_ready), 32'd1);
        check("wrst_rdata", a_rsp_rdata, 32'd0);
        check("wrst_err", 32'(a_rsp_err), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("wrst_no_rsp", 32'(a_rsp_valid), 32'd0);
            step();
        end
        a_access("ld10_post_rst", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // LATENCY=1 instance: store, then back-to-back loads with rsp_ready tied high.
        b_rsp_ready = 1'b1;
        b_req_valid = 1'b1;
        b_req_write = 1'b1;
        b_req_addr  = 32'h8;
        b_req_wdata = 32'h01020304;
        b_req_be    = 4'hF;
        step();
        check("b_st_valid", 32'(b_rsp_valid), 32'd1);
        check("b_st_rdata", b_rsp_rdata, 32'd0);
        check("b_st_err", 32'(b_rsp_err), 32'd0);
        check("b_st_req_ready", 32'(b_req_ready), 32'd0);
        b_req_write = 1'b0;
        step();
        check("b_idle_valid", 32'(b_rsp_valid), 32'd0);
        check("b_idle_req_ready", 32'(b_req_ready), 32'd1);
        nresp = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("b_b2b_valid", 32'(b_rsp_valid), 32'((i % 2) == 0));
            check("b_b2b_req_ready", 32'(b_req_ready), 32'((i % 2) == 1));
            if (b_rsp_valid) begin
                nresp++;
                check("b_b2b_rdata", b_rsp_rdata, 32'h01020304);
            end
        end
        b_req_valid = 1'b0;
        check("b_b2b_count", 32'(nresp), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words in the data store (power of two, at least 4).
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response valid (range 1..15; 0 illegal).
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req_valid  input  1  core presents a load/store request.
REQ-006 Port req_ready  output  1  responder can accept a request this cycle.
REQ-007 Port req_write  input  1  1 = store, 0 = load.
REQ-008 Port req_addr  input  32  byte address.
REQ-009 Port req_wdata  input  32  store data.
REQ-010 Port req_be  input  4  store byte enables; bit i selects byte i (little-endian).
REQ-011 Port rsp_valid  output  1  response available.
REQ-012 Port rsp_ready  input  1  core accepts the response.
REQ-013 Port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 Port rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-017 On acceptance, the responder SHALL capture write flag, address, wdata and be, and load the latency counter with LATENCY-1.
REQ-018 After acceptance, the FSM SHALL go to RESP if LATENCY=1, otherwise to WAIT.
REQ-019 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL move to RESP on the edge where the counter equals 1.
REQ-020 rsp_valid SHALL be 1 exactly in RESP, first asserted LATENCY cycles after the acceptance edge.
REQ-021 rsp_rdata and rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-022 On a RESP-cycle edge with rsp_ready=1, the FSM SHALL return to IDLE; no new request is accepted in that same cycle.
REQ-023 Word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2].
REQ-024 An error SHALL be flagged when req_addr[1:0] is not 0, or when req_addr is at least DEPTH_WORDS*4.
REQ-025 An errored store SHALL not modify memory; an errored load SHALL return rdata 0; the response SHALL carry rsp_err=1.
REQ-026 A valid store SHALL update only the bytes selected by req_be on the acceptance edge; req_be=0 SHALL complete as a no-op with a normal response.
REQ-027 A valid load SHALL read memory at the acceptance edge, so a load accepted after a store observes the store.
REQ-028 Store responses SHALL return rsp_rdata=0 and rsp_err=0 when valid.
REQ-029 Requests presented outside IDLE SHALL be ignored; the core must hold req_valid until accepted.

Reset
REQ-030 On a reset edge, the state SHALL go to IDLE and the counter SHALL clear to 0.
REQ-031 On a reset edge, rsp_valid, rsp_rdata and rsp_err SHALL clear to 0; req_ready SHALL be 1 in the first cycle after reset.
REQ-032 Reset during WAIT or RESP SHALL drop the pending response silently; a store already committed on acceptance stays committed.
REQ-033 Memory contents SHALL not be cleared by reset.

Structure
REQ-034 Package dmem_pkg SHALL hold the state enum, the DATA_W=32 and BE_W=4 constants, and the error-check function.
REQ-035 The byte-enabled synchronous storage SHALL be a sub-module named dmem_array; the FSM, counter and checks live in dmem_responder.

Verification
REQ-036 With LATENCY=2: store addr 0x10, data 0xDEADBEEF, be 0xF, then load 0x10 -> store response at acceptance+2 with err 0; load returns 0xDEADBEEF at acceptance+2.
REQ-037 Store 0x11223344 to 0x20, then store 0xAABBCCDD to 0x20 with be 0x5, then load 0x20 -> returns 0x11BB33DD.
REQ-038 Load 0x22 (misaligned) and load 0x400 with DEPTH_WORDS=256 (out of range) -> rsp_err=1 and rdata 0 for both; memory unchanged.
REQ-039 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1 with stable data and req_ready stays 0; after the rsp_ready edge, req_ready=1 in the next cycle.
REQ-040 Assert reset in WAIT after a load is accepted -> no response ever appears, outputs are 0, and a following load of 0x10 returns 0xDEADBEEF.
REQ-041 With LATENCY=1, issue back-to-back loads with rsp_ready tied to 1 -> one response every 2 cycles, each one cycle after its acceptance.
